// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch FSM state encoding and instruction width
package cpu_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_addr_chk.sv
// rtl/fetch_addr_chk.sv - combinational fetch-address legality check
module fetch_addr_chk
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic [63:0] pc,
  output logic        illegal
);

  logic [64:0] last_byte;

  // Widen to 65 bits so pc+3 cannot wrap and sneak past the size bound
  always_comb begin
    last_byte = {1'b0, pc} + 65'd3;
    illegal   = (pc[1:0] != 2'b00) || (last_byte >= 65'(MEM_SIZE));
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller; FETCH_PERF_EN adds fetch/bubble counters
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [63:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [63:0]        br_target,
  output logic [INSTR_W-1:0] out_instr,
  output logic [63:0]        out_pc,
  output logic               out_valid,
  output logic               fault,
`ifdef FETCH_PERF_EN
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        bubble_cnt,
`endif
  output logic [63:0]        fault_pc
);

  fetch_state_e       state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [63:0]        out_pc_q, out_pc_d;
  logic               out_valid_q, out_valid_d;
  logic               fault_q, fault_d;
  logic [63:0]        fault_pc_q, fault_pc_d;
  logic               pc_illegal;

`ifdef FETCH_PERF_EN
  logic [31:0]        fetch_cnt_q, fetch_cnt_d;
  logic [31:0]        bubble_cnt_q, bubble_cnt_d;
`endif

  fetch_addr_chk #(
    .MEM_SIZE (MEM_SIZE)
  ) u_addr_chk (
    .pc      (pc_q),
    .illegal (pc_illegal)
  );

  assign imem_addr = pc_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign out_valid = out_valid_q;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;
`ifdef FETCH_PERF_EN
  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

  // Next-state logic: redirect beats stall, stall beats fetch, fault is terminal until reset
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_valid_d = out_valid_q;
    fault_d     = fault_q;
    fault_pc_d  = fault_pc_q;
`ifdef FETCH_PERF_EN
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
`endif
    case (state_q)
      BOOT: begin
        state_d     = RUN;
        out_valid_d = 1'b0;
      end
      RUN: begin
`ifdef FETCH_PERF_EN
        if (br_taken || stall) begin
          bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
`endif
        if (br_taken) begin
          // Target legality is deliberately not checked here; it faults on fetch
          pc_d        = br_target;
          out_valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (!pc_illegal) begin
          out_instr_d = imem_instr;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + 64'd4;
`ifdef FETCH_PERF_EN
          fetch_cnt_d = fetch_cnt_q + 32'd1;
`endif
        end else begin
          state_d     = FAULT;
          fault_d     = 1'b1;
          fault_pc_d  = pc_q;
          out_valid_d = 1'b0;
        end
      end
      FAULT: begin
        out_valid_d = 1'b0;
        fault_d     = 1'b1;
      end
      default: begin
        state_d     = BOOT;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Register all state and outputs; synchronous reset wins from any state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      out_instr_q <= '0;
      out_pc_q    <= 64'd0;
      out_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      fault_pc_q  <= 64'd0;
`ifdef FETCH_PERF_EN
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
      fault_q     <= fault_d;
      fault_pc_q  <= fault_pc_d;
`ifdef FETCH_PERF_EN
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
`endif
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, instruction memory size in bytes (power of two, >4).
REQ-002 SHALL have parameter RESET_PC, default 64'd0, first fetch address after reset.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  in  1  synchronous active-high reset.
REQ-005 SHALL have port imem_addr  out  64  byte address driven to the instruction ROM.
REQ-006 SHALL have port imem_instr  in  32  combinational ROM read data for imem_addr.
REQ-007 SHALL have port stall  in  1  downstream hold request.
REQ-008 SHALL have port br_taken  in  1  redirect request.
REQ-009 SHALL have port br_target  in  64  redirect byte address.
REQ-010 SHALL have port out_instr  out  32  registered fetched instruction.
REQ-011 SHALL have port out_pc  out  64  address of out_instr.
REQ-012 SHALL have port out_valid  out  1  out_instr/out_pc hold a valid fetch.
REQ-013 SHALL have port fault  out  1  sticky fetch-address fault flag.
REQ-014 SHALL have port fault_pc  out  64  address that caused the fault.

Function
REQ-015 SHALL implement FSM states BOOT, RUN, FAULT; BOOT lasts exactly one cycle after reset deasserts, then RUN.
REQ-016 SHALL drive imem_addr combinationally from the internal pc register in every state.
REQ-017 SHALL treat pc as illegal when pc[1:0]!=0 or pc+3 >= MEM_SIZE (64-bit unsigned compare, no wrap).
REQ-018 SHALL, in RUN with br_taken=1, load pc<=br_target, clear out_valid, and hold out_instr/out_pc (one bubble); br_taken outranks stall and the illegal check.
REQ-019 SHALL, in RUN with br_taken=0 and stall=1, hold pc, out_instr, out_pc, out_valid unchanged.
REQ-020 SHALL, in RUN with br_taken=0, stall=0 and pc legal, capture out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+4.
REQ-021 SHALL, in RUN with br_taken=0, stall=0 and pc illegal, enter FAULT, set fault=1, fault_pc<=pc, out_valid<=0.
REQ-022 SHALL, in FAULT, ignore stall and br_taken, hold pc, keep out_valid=0 and fault=1 until reset.
REQ-023 SHALL, in BOOT, keep out_valid=0 and pc=RESET_PC; inputs ignored.
REQ-024 SHALL let an illegal br_target be accepted and fault only when fetched (REQ-021).

Reset
REQ-025 SHALL on reset set state=BOOT, pc=RESET_PC, out_instr=32'd0, out_pc=64'd0, out_valid=0, fault=0, fault_pc=64'd0.
REQ-026 SHALL let reset override any state including mid-stall and FAULT, taking effect the next edge.

Configuration
REQ-027 SHALL, when FETCH_PERF_EN is defined, add outputs fetch_cnt[31:0] (+1 per REQ-020 capture) and bubble_cnt[31:0] (+1 per RUN cycle with stall or br_taken), both reset to 0, wrapping at 2^32.
REQ-028 SHALL, when FETCH_PERF_EN is undefined, omit those ports and counters entirely with no other behavioural change.

Structure
REQ-029 SHALL place the state enum (BOOT/RUN/FAULT) and the instruction width constant (32) in shared package cpu_pkg.
REQ-030 SHALL isolate the legality check in sub-module fetch_addr_chk (pc, MEM_SIZE -> illegal), purely combinational.

Verification
REQ-031 Reset then 4 free cycles, ROM words 0..3 = A,B,C,D -> out_valid=0 in BOOT, then out_pc 0,4,8 with out_instr A,B,C.
REQ-032 stall=1 for 3 cycles at pc=8 -> out_pc=4/out_instr=B held, imem_addr=8 held; stall=0 -> out_pc=8.
REQ-033 br_taken=1, br_target=0x40, same cycle stall=1 -> next cycle out_valid=0, imem_addr=0x40; then out_pc=0x40.
REQ-034 Branch to 0x3FC with MEM_SIZE=1024 -> fetch at 0x3FC valid; next pc 0x400 -> fault=1, fault_pc=0x400, out_valid=0, stays in FAULT with br_taken pulses.
REQ-035 Branch to 0x42 -> fault=1, fault_pc=0x42; reset asserted in FAULT -> all outputs to REQ-025 values, fetch resumes from 0.
REQ-036 With FETCH_PERF_EN, 5 fetches, 2 stalls, 1 branch -> fetch_cnt=5, bubble_cnt=3.
